// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: entry field widths, the
// exception-tag default and the pointer-width helper.
// Optional feature macro: IQ_EXC_TAG_EN (adds a 1-bit fetch exception tag per entry).
package inst_queue_pkg;

    localparam int unsigned IQ_INST_W = 32;
    localparam int unsigned IQ_PC_W   = 32;

`ifdef IQ_EXC_TAG_EN
    localparam bit IQ_EXC_TAG_ON = 1'b1;
`else
    localparam bit IQ_EXC_TAG_ON = 1'b0;
`endif

    // Total stored bits per entry.
    localparam int unsigned IQ_ENTRY_W = IQ_INST_W + IQ_PC_W + (IQ_EXC_TAG_ON ? 1 : 0);

    typedef struct packed {
`ifdef IQ_EXC_TAG_EN
        logic                 exc;
`endif
        logic [IQ_INST_W-1:0] inst;
        logic [IQ_PC_W-1:0]   pc;
    } iq_entry_t;

    // Pointer width for a power-of-two queue depth.
    function automatic int unsigned iq_ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Storage array for the instruction queue: DEPTH entries, two write ports,
// two combinational read ports, no reset.
module inst_queue_ram #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 64,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          we_0,
    input  logic [AW-1:0] waddr_0,
    input  logic [W-1:0]  wdata_0,
    input  logic          we_1,
    input  logic [AW-1:0] waddr_1,
    input  logic [W-1:0]  wdata_1,
    input  logic [AW-1:0] raddr_0,
    output logic [W-1:0]  rdata_0,
    input  logic [AW-1:0] raddr_1,
    output logic [W-1:0]  rdata_1
);

    logic [W-1:0] mem [DEPTH];

    // The two write addresses are always distinct (tail and tail+1).
    always_ff @(posedge clk) begin
        if (we_0) mem[waddr_0] <= wdata_0;
        if (we_1) mem[waddr_1] <= wdata_1;
    end

    assign rdata_0 = mem[raddr_0];
    assign rdata_1 = mem[raddr_1];

endmodule

// File: rtl/inst_queue.sv
// Dual-port instruction FIFO between fetch and the stage-1 decoders.
// Accepts up to two words per cycle, presents the two oldest, retires d_issue_cnt.
// Optional feature macro: IQ_EXC_TAG_EN (per-entry fetch exception tag).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [1:0]                  f_w_ena,
    input  logic [IQ_INST_W-1:0]        f_inst_0,
    input  logic [IQ_INST_W-1:0]        f_inst_1,
    input  logic [IQ_PC_W-1:0]          f_pc_0,
    input  logic [IQ_PC_W-1:0]          f_pc_1,
`ifdef IQ_EXC_TAG_EN
    input  logic                        f_exc_0,
    input  logic                        f_exc_1,
`endif
    output logic                        f_ready,
    output logic [1:0]                  d_valid,
    output logic [IQ_INST_W-1:0]        d_inst_0,
    output logic [IQ_INST_W-1:0]        d_inst_1,
    output logic [IQ_PC_W-1:0]          d_pc_0,
    output logic [IQ_PC_W-1:0]          d_pc_1,
`ifdef IQ_EXC_TAG_EN
    output logic                        d_exc_0,
    output logic                        d_exc_1,
`endif
    input  logic [1:0]                  d_issue_cnt,
    output logic [iq_ptr_w(DEPTH):0]    q_count
);

    localparam int unsigned AW = iq_ptr_w(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          wr_go, we_0, we_1;
    logic [1:0]    n_wr;
    iq_entry_t     wdata_0, wdata_1, rdata_0, rdata_1;

    // Ready looks only at registered occupancy, never at this cycle's issue.
    assign f_ready = (count_q <= CW'(DEPTH - 2));
    assign wr_go   = f_ready & ~flush;
    assign we_0    = wr_go & f_w_ena[0];
    assign we_1    = wr_go & f_w_ena[1];
    assign n_wr    = {1'b0, we_0} + {1'b0, we_1};

    assign wdata_0.inst = f_inst_0;
    assign wdata_0.pc   = f_pc_0;
    assign wdata_1.inst = f_inst_1;
    assign wdata_1.pc   = f_pc_1;
`ifdef IQ_EXC_TAG_EN
    assign wdata_0.exc  = f_exc_0;
    assign wdata_1.exc  = f_exc_1;
`endif

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .W     (IQ_ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_0    (we_0),
        .waddr_0 (tail_q),
        .wdata_0 (wdata_0),
        .we_1    (we_1),
        .waddr_1 (tail_q + AW'(1)),
        .wdata_1 (wdata_1),
        .raddr_0 (head_q),
        .rdata_0 (rdata_0),
        .raddr_1 (head_q + AW'(1)),
        .rdata_1 (rdata_1)
    );

    // Next pointers and occupancy; flush overrides any write or issue.
    always_comb begin
        head_d  = head_q + AW'(d_issue_cnt);
        tail_d  = tail_q + AW'(n_wr);
        count_d = count_q + CW'(n_wr) - CW'(d_issue_cnt);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign d_valid  = {count_q >= CW'(2), count_q != '0};
    assign q_count  = count_q;
    assign d_inst_0 = rdata_0.inst;
    assign d_inst_1 = rdata_1.inst;
    assign d_pc_0   = rdata_0.pc;
    assign d_pc_1   = rdata_1.pc;
`ifdef IQ_EXC_TAG_EN
    assign d_exc_0  = rdata_0.exc;
    assign d_exc_1  = rdata_1.exc;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_inst_queue;

    localparam int unsigned DEPTH = 8;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        exc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [1:0]  f_w_ena = 2'b00;
    logic [31:0] f_inst_0 = '0, f_inst_1 = '0, f_pc_0 = '0, f_pc_1 = '0;
    logic        f_exc_0 = 1'b0, f_exc_1 = 1'b0;
    logic        f_ready;
    logic [1:0]  d_valid;
    logic [31:0] d_inst_0, d_inst_1, d_pc_0, d_pc_1;
    logic        d_exc_0, d_exc_1;
    logic [1:0]  d_issue_cnt = 2'd0;
    logic [3:0]  q_count;

    ent_t model[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

`ifndef IQ_EXC_TAG_EN
    assign d_exc_0 = 1'b0;
    assign d_exc_1 = 1'b0;
`endif

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .f_w_ena     (f_w_ena),
        .f_inst_0    (f_inst_0),
        .f_inst_1    (f_inst_1),
        .f_pc_0      (f_pc_0),
        .f_pc_1      (f_pc_1),
`ifdef IQ_EXC_TAG_EN
        .f_exc_0     (f_exc_0),
        .f_exc_1     (f_exc_1),
`endif
        .f_ready     (f_ready),
        .d_valid     (d_valid),
        .d_inst_0    (d_inst_0),
        .d_inst_1    (d_inst_1),
        .d_pc_0      (d_pc_0),
        .d_pc_1      (d_pc_1),
`ifdef IQ_EXC_TAG_EN
        .d_exc_0     (d_exc_0),
        .d_exc_1     (d_exc_1),
`endif
        .d_issue_cnt (d_issue_cnt),
        .q_count     (q_count)
    );

    // Drive one cycle of inputs, advance the reference model, sample #1 after the edge.
    task automatic drive_cycle(input logic fl, input logic [1:0] wena,
                               input logic [31:0] i0, input logic [31:0] p0, input logic e0,
                               input logic [31:0] i1, input logic [31:0] p1, input logic e1,
                               input logic [1:0] iss);
        bit ready;
        ent_t e;
        flush = fl; f_w_ena = wena; d_issue_cnt = iss;
        f_inst_0 = i0; f_pc_0 = p0; f_exc_0 = e0;
        f_inst_1 = i1; f_pc_1 = p1; f_exc_1 = e1;
        ready = (model.size() + 2 <= DEPTH);
        if (fl) begin
            model.delete();
        end else begin
            for (int k = 0; k < int'(iss); k++) void'(model.pop_front());
            if (ready && wena[0]) begin e.inst = i0; e.pc = p0; e.exc = e0; model.push_back(e); end
            if (ready && wena[1]) begin e.inst = i1; e.pc = p1; e.exc = e1; model.push_back(e); end
        end
        @(posedge clk);
        #1;
        flush = 1'b0; f_w_ena = 2'b00; d_issue_cnt = 2'd0;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd0);
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", q_count); end
        n_cmp++; if (d_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid got=%b want=00", d_valid); end
        n_cmp++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b want=1", f_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive_cycle(1'b0, 2'b11, 32'h24010001, 32'hBFC00000, 1'b0,
                    32'h24020002, 32'hBFC00004, 1'b0, 2'd0);
        n_cmp++; if (d_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid got=%b want=11", d_valid); end
        n_cmp++; if (d_inst_0 !== 32'h24010001) begin n_fail++; $display("FAIL basic_inst0 got=%h want=24010001", d_inst_0); end
        n_cmp++; if (d_pc_1 !== 32'hBFC00004) begin n_fail++; $display("FAIL basic_pc1 got=%h want=bfc00004", d_pc_1); end
        n_cmp++; if (q_count !== 4'd2) begin n_fail++; $display("FAIL basic_count got=%0d want=2", q_count); end
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd2);
        n_cmp++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL basic_drain got=%0d want=0", q_count); end
    endtask

    task automatic test_fill();
        drive_cycle(1'b0, 2'b01, 32'h100, 32'h0, 1'b0, '0, '0, 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (f_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_early cnt=%0d got=%b want=1", q_count, f_ready); end
            drive_cycle(1'b0, 2'b11, 32'h101 + 2 * k, 32'h4 + 8 * k, 1'b0,
                        32'h102 + 2 * k, 32'h8 + 8 * k, 1'b0, 2'd0);
        end
        n_cmp++; if (q_count !== 4'd7) begin n_fail++; $display("FAIL fill_count got=%0d want=7", q_count); end
        n_cmp++; if (f_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_full got=%b want=0", f_ready); end
        drive_cycle(1'b0, 2'b11, 32'hDEAD, 32'hDEAD, 1'b0, 32'hBEEF, 32'hBEEF, 1'b0, 2'd0);
        n_cmp++; if (q_count !== 4'd7) begin n_fail++; $display("FAIL fill_drop got=%0d want=7", q_count); end
        for (int k = 0; k < 7; k++) begin
            n_cmp++; if (d_inst_0 !== 32'h100 + k) begin n_fail++; $display("FAIL fill_order k=%0d got=%h want=%h", k, d_inst_0, 32'h100 + k); end
            drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd1);
        end
        n_cmp++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL fill_empty got=%0d want=0", q_count); end
    endtask

    task automatic test_wrap();
        drive_cycle(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd0);
        drive_cycle(1'b0, 2'b01, 32'h0, 32'h0, 1'b0, '0, '0, 1'b0, 2'd0);
        for (int k = 1; k < 7; k++)
            drive_cycle(1'b0, 2'b01, k, 4 * k, 1'b0, '0, '0, 1'b0, 2'd1);
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd1);
        // head = tail = 7, empty
        drive_cycle(1'b0, 2'b11, 32'hAAAA0007, 32'h00001000, 1'b0,
                    32'hBBBB0000, 32'h00001004, 1'b0, 2'd0);
        n_cmp++; if (d_valid !== 2'b11) begin n_fail++; $display("FAIL wrap_valid got=%b want=11", d_valid); end
        n_cmp++; if (d_pc_0 !== 32'h1000 || d_inst_0 !== 32'hAAAA0007) begin n_fail++; $display("FAIL wrap_head got=%h/%h want=00001000/aaaa0007", d_pc_0, d_inst_0); end
        n_cmp++; if (d_pc_1 !== 32'h1004 || d_inst_1 !== 32'hBBBB0000) begin n_fail++; $display("FAIL wrap_next got=%h/%h want=00001004/bbbb0000", d_pc_1, d_inst_1); end
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd1);
        n_cmp++; if (d_pc_0 !== 32'h1004) begin n_fail++; $display("FAIL wrap_adv got=%h want=00001004", d_pc_0); end
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd1);
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b0, 2'b11, 32'h1, 32'h2000, 1'b0, 32'h2, 32'h2004, 1'b0, 2'd0);
        drive_cycle(1'b0, 2'b01, 32'h3, 32'h2008, 1'b0, '0, '0, 1'b0, 2'd0);
        n_cmp++; if (q_count !== 4'd3) begin n_fail++; $display("FAIL simul_pre got=%0d want=3", q_count); end
        drive_cycle(1'b0, 2'b11, 32'h4, 32'h200C, 1'b0, 32'h5, 32'h2010, 1'b0, 2'd1);
        n_cmp++; if (q_count !== 4'd4) begin n_fail++; $display("FAIL simul_rw got=%0d want=4", q_count); end
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd2);
        n_cmp++; if (q_count !== 4'd2) begin n_fail++; $display("FAIL simul_iss2 got=%0d want=2", q_count); end
        n_cmp++; if (d_pc_0 !== 32'h200C) begin n_fail++; $display("FAIL simul_pc got=%h want=0000200c", d_pc_0); end
    endtask

    task automatic test_flush();
        drive_cycle(1'b1, 2'b11, 32'h77, 32'h77, 1'b0, 32'h78, 32'h78, 1'b0, 2'd2);
        n_cmp++; if (d_valid !== 2'b00) begin n_fail++; $display("FAIL flush_valid got=%b want=00", d_valid); end
        n_cmp++; if (q_count !== 4'd0) begin n_fail++; $display("FAIL flush_count got=%0d want=0", q_count); end
        drive_cycle(1'b0, 2'b01, 32'h12345678, 32'h3000, 1'b0, '0, '0, 1'b0, 2'd0);
        n_cmp++; if (d_valid !== 2'b01 || d_inst_0 !== 32'h12345678) begin n_fail++; $display("FAIL flush_after got=%b/%h want=01/12345678", d_valid, d_inst_0); end
        drive_cycle(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd0);
    endtask

`ifdef IQ_EXC_TAG_EN
    task automatic test_exc_tag();
        drive_cycle(1'b0, 2'b11, 32'h9, 32'h4000, 1'b1, 32'hA, 32'h4004, 1'b0, 2'd0);
        n_cmp++; if (d_exc_0 !== 1'b1 || d_exc_1 !== 1'b0) begin n_fail++; $display("FAIL exc_tag got=%b%b want=10", d_exc_0, d_exc_1); end
        drive_cycle(1'b0, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd1);
        n_cmp++; if (d_exc_0 !== 1'b0 || d_pc_0 !== 32'h4004) begin n_fail++; $display("FAIL exc_adv got=%b/%h want=0/00004004", d_exc_0, d_pc_0); end
        drive_cycle(1'b1, 2'b00, '0, '0, 1'b0, '0, '0, 1'b0, 2'd0);
    endtask
`endif

    task automatic test_async_reset();
        drive_cycle(1'b0, 2'b11, 32'h1, 32'h1, 1'b0, 32'h2, 32'h2, 1'b0, 2'd0);
        drive_cycle(1'b0, 2'b01, 32'h3, 32'h3, 1'b0, '0, '0, 1'b0, 2'd0);
        n_cmp++; if (q_count !== 4'd3) begin n_fail++; $display("FAIL arst_pre got=%0d want=3", q_count); end
        rst = 1'b1;
        #1;
        n_cmp++; if (q_count !== 4'd0 || d_valid !== 2'b00 || f_ready !== 1'b1) begin n_fail++; $display("FAIL arst_now got=%0d/%b/%b want=0/00/1", q_count, d_valid, f_ready); end
        model.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] wena, iss;
        int unsigned sz;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(2, 0))
                0: wena = 2'b00;
                1: wena = 2'b01;
                default: wena = 2'b11;
            endcase
            sz = model.size();
            iss = 2'($urandom_range((sz > 2) ? 2 : sz, 0));
            drive_cycle(($urandom_range(31, 0) == 0), wena,
                        $urandom, $urandom & 32'hFFFFFFFC, 1'($urandom),
                        $urandom, $urandom & 32'hFFFFFFFC, 1'($urandom), iss);
            sz = model.size();
            n_cmp++; if (q_count !== 4'(sz)) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, q_count, sz); end
            n_cmp++; if (f_ready !== (sz + 2 <= DEPTH)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, f_ready, (sz + 2 <= DEPTH)); end
            n_cmp++; if (d_valid !== {sz >= 2, sz >= 1}) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b want=%b%b", c, d_valid, sz >= 2, sz >= 1); end
            if (sz >= 1) begin
                n_cmp++;
                if (d_inst_0 !== model[0].inst || d_pc_0 !== model[0].pc) begin
                    n_fail++; $display("FAIL rnd_slot0 c=%0d got=%h@%h want=%h@%h", c, d_inst_0, d_pc_0, model[0].inst, model[0].pc);
                end
`ifdef IQ_EXC_TAG_EN
                n_cmp++; if (d_exc_0 !== model[0].exc) begin n_fail++; $display("FAIL rnd_exc0 c=%0d got=%b want=%b", c, d_exc_0, model[0].exc); end
`endif
            end
            if (sz >= 2) begin
                n_cmp++;
                if (d_inst_1 !== model[1].inst || d_pc_1 !== model[1].pc) begin
                    n_fail++; $display("FAIL rnd_slot1 c=%0d got=%h@%h want=%h@%h", c, d_inst_1, d_pc_1, model[1].inst, model[1].pc);
                end
`ifdef IQ_EXC_TAG_EN
                n_cmp++; if (d_exc_1 !== model[1].exc) begin n_fail++; $display("FAIL rnd_exc1 c=%0d got=%b want=%b", c, d_exc_1, model[1].exc); end
`endif
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_back_to_back();
        test_flush();
`ifdef IQ_EXC_TAG_EN
        test_exc_tag();
`endif
        test_async_reset();
        test_random();
        idle_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
